decode_queue: RTL
=================

# decode_queue

Buffered, parametrised decode stage between the instruction fetcher and the dispatcher. Each raw RV32I word is decoded on enqueue and the decoded fields are held in a DEPTH-entry FIFO. Entries leave through a valid/ready handshake, and the whole queue can be flushed on redirect. Over a bare combinational decoder, the block adds buffering, PC tracking, precomputed jump/branch targets and a selectable strict illegal-instruction check.

## Interface
- DEPTH_WIDTH, 2: queue depth = 2^DEPTH_WIDTH entries.
- STRICT, 1: 1 = full funct7/funct3 legality check; 0 = lax check (unknown opcode or unused funct3 only).
- clk_in  in  1  clock; all state changes on rising edge.
- rst_in  in  1  reset; one clock; reset is asynchronous and active-high.
- rdy_in  in  1  global enable; low = hold all state, suppress handshakes.
- flush  in  1  discard all entries (branch mispredict / redirect).
- in_valid  in  1  fetcher offers in_inst/in_pc.
- in_ready  out  1  queue accepts this cycle.
- in_inst  in  32  raw instruction word.
- in_pc  in  32  address of in_inst.
- out_valid  out  1  head entry valid.
- out_ready  in  1  dispatcher consumes head.
- out_op  out  7  internal op code; 0 = illegal.
- out_rs1, out_rs2, out_rd  out  5 each  raw fields [19:15], [24:20], [11:7].
- out_imm  out  32  decoded immediate.
- out_pc  out  32  entry PC.
- out_target  out  32  in_pc+imm for jal/B-type; in_pc+4 otherwise (mod 2^32).
- out_illegal  out  1  entry failed legality check.
- count  out  DEPTH_WIDTH+1  occupied entries.

## Operation
- Op enumeration, 1..37 in order: lui, auipc, jal, jalr, beq, bne, blt, bge, bltu, bgeu, lb, lh, lw, lbu, lhu, sb, sh, sw, addi, slti, sltiu, xori, ori, andi, slli, srli, srai, add, sub, sll, slt, sltu, xor, srl, sra, or, and.
- Immediates:
  - lui/auipc: {inst[31:12], 12'b0}.
  - jal: J-format, sign-extended.
  - jalr/loads/ALU-imm: inst[31:20] sign-extended.
  - B-type and S-type: standard formats, sign-extended.
  - slli/srli/srai: zero-extended inst[24:20].
  - R-type: 0.
- Illegal, both modes: opcode outside the 9 RV32I classes; unused funct3 in B/L/S/R/ALU-imm classes.
- Illegal, STRICT=1 only:
  - jalr funct3 != 0.
  - slli funct7 != 0.
  - srli/srai funct7 other than 0000000/0100000.
  - R-type funct7 other than 0000000, or 0100000 with anything but add/sub or srl/sra.
- STRICT=0 lax rules:
  - srli/srai select on funct7[5:0]==0.
  - R-type add/sub and srl/sra select on funct7==0, so any nonzero funct7 gives sub/sra.
  - Other R-type funct7 values are ignored.
- Illegal entry contents: op=0, imm=0, illegal=1, target=pc+4. The entry is still queued, in order.
- Storage: circular buffer, head/tail pointers wrap modulo 2^DEPTH_WIDTH, with a separate count.
- in_ready = rdy_in & !rst_in & (count < DEPTH). There is no push-when-full even if a pop happens in the same cycle.
- out_valid = rdy_in & (count != 0). There is no empty bypass.
- Push = in_valid & in_ready. Pop = out_valid & out_ready. Push and pop together leave count unchanged.
- Flush (when rdy_in=1) overrides push and pop that cycle: head=tail=count=0.
- Output fields come from the head entry. All out_* fields are 0 when count=0.

## Timing
- Reset (asynchronous): head=tail=count=0, all entry storage 0, out_valid=0, in_ready=0, all out_* fields 0.
- Reset mid-operation: all entries are lost immediately, without waiting for a clock edge.
- Latency: an instruction pushed at edge N appears on out_* after edge N (valid in cycle N+1).
- Throughput: 1 push and 1 pop per cycle.
- The head is visible combinationally from storage. Outputs stay stable while out_valid=1 and out_ready=0.
- rdy_in=0: no pointer, count or storage change, including flush; in_ready=0 and out_valid=0.
- Flush at edge N: out_valid=0 in cycle N+1, in_ready=1 in cycle N+1.

## Test plan
- Reset, push 0x00500093 (addi x1,x0,5) at pc 0x0 -> next cycle out_valid=1, op=19, rd=1, rs1=0, imm=5, target=0x4, count=1.
- Push 0xFF9FF06F (jal x0,-8) at pc 0x100 -> imm=0xFFFFFFF8, target=0xF8, op=3.
- Push 0x00208863 (beq x1,x2,+16) at pc 0x200 -> imm=16, rs1=1, rs2=2, target=0x210.
- DEPTH_WIDTH=2:
  - Push 5 instructions with out_ready=0 -> count=4, in_ready=0, 5th not accepted; popping yields the first 4 in order.
  - Push+pop at count=4 -> no push; count=3.
  - Push+pop at count=2 -> count stays 2.
  - Flush with push and pop asserted -> count=0, out_valid=0 next cycle.
- Push 0x40001093 -> STRICT=1: op=0, illegal=1; STRICT=0: op=25, illegal=0. Push 0x0000007F -> illegal=1 in both modes.
- rdy_in=0 with in_valid=1, out_ready=1, flush=1 for 3 cycles -> count and head unchanged. Assert rst_in mid-burst -> count=0, out_valid=0 immediately.

Source files
------------

// File: rtl/decode_queue.sv
// decode_queue: RV32I decode stage feeding a 2^DEPTH_WIDTH-entry FIFO of decoded fields.
// Ports: clk_in/rst_in (async active-high) clock and reset; rdy_in global enable; flush empties queue;
//        in_valid/in_ready/in_inst/in_pc fetch side; out_valid/out_ready plus out_* decoded head entry;
//        count occupied entries. STRICT selects full funct7/funct3 legality checking.
module decode_queue #(
    parameter int DEPTH_WIDTH = 2,
    parameter int STRICT = 1
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_inst,
    input  logic [31:0]            in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [6:0]             out_op,
    output logic [4:0]             out_rs1,
    output logic [4:0]             out_rs2,
    output logic [4:0]             out_rd,
    output logic [31:0]            out_imm,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_target,
    output logic                   out_illegal,
    output logic [DEPTH_WIDTH:0]   count
);
    localparam int DEPTH = 2 ** DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] DEPTH_N = (DEPTH_WIDTH + 1)'(DEPTH);

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] target;
        logic        illegal;
    } ent_t;

    ent_t mem [DEPTH];
    ent_t dec, head_ent;
    logic [DEPTH_WIDTH-1:0] head, tail;
    logic push, pop;

    logic [2:0]  f3;
    logic [6:0]  f7, dop, rbase;
    logic [31:0] dimm, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        jump, alt;

    assign f3    = in_inst[14:12];
    assign f7    = in_inst[31:25];
    assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {in_inst[31:12], 12'b0};
    assign imm_j = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    // funct3 000 and 101 are the only R-type slots with a funct7-selected alternate (sub/sra)
    assign alt   = (f3 == 3'd0) || (f3 == 3'd5);

    always_comb begin
        dop   = 7'd0;
        dimm  = 32'd0;
        jump  = 1'b0;
        rbase = 7'd0;
        case (in_inst[6:0])
            7'b0110111: begin dop = 7'd1; dimm = imm_u; end
            7'b0010111: begin dop = 7'd2; dimm = imm_u; end
            7'b1101111: begin dop = 7'd3; dimm = imm_j; jump = 1'b1; end
            7'b1100111: begin dop = (STRICT == 0 || f3 == 3'd0) ? 7'd4 : 7'd0; dimm = imm_i; end
            7'b1100011: begin
                dop  = (f3 == 3'd0) ? 7'd5 : (f3 == 3'd1) ? 7'd6 : f3[2] ? 7'd7 + {5'd0, f3[1:0]} : 7'd0;
                dimm = imm_b;
                jump = 1'b1;
            end
            7'b0000011: begin
                case (f3)
                    3'd0: dop = 7'd11;
                    3'd1: dop = 7'd12;
                    3'd2: dop = 7'd13;
                    3'd4: dop = 7'd14;
                    3'd5: dop = 7'd15;
                    default: dop = 7'd0;
                endcase
                dimm = imm_i;
            end
            7'b0100011: begin dop = (f3 < 3'd3) ? 7'd16 + {4'd0, f3} : 7'd0; dimm = imm_s; end
            7'b0010011: begin
                case (f3)
                    3'd0: dop = 7'd19;
                    3'd2: dop = 7'd20;
                    3'd3: dop = 7'd21;
                    3'd4: dop = 7'd22;
                    3'd6: dop = 7'd23;
                    3'd7: dop = 7'd24;
                    3'd1: dop = (STRICT == 0 || f7 == 7'd0) ? 7'd25 : 7'd0;
                    default: dop = (STRICT != 0) ? ((f7 == 7'd0) ? 7'd26 : (f7 == 7'h20) ? 7'd27 : 7'd0)
                                                 : ((f7[5:0] == 6'd0) ? 7'd26 : 7'd27);
                endcase
                dimm = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, in_inst[24:20]} : imm_i;
            end
            7'b0110011: begin
                case (f3)
                    3'd0: rbase = 7'd28;
                    3'd1: rbase = 7'd30;
                    3'd2: rbase = 7'd31;
                    3'd3: rbase = 7'd32;
                    3'd4: rbase = 7'd33;
                    3'd5: rbase = 7'd34;
                    3'd6: rbase = 7'd36;
                    default: rbase = 7'd37;
                endcase
                dop = (STRICT != 0) ? ((f7 == 7'd0) ? rbase : (f7 == 7'h20 && alt) ? rbase + 7'd1 : 7'd0)
                                    : ((alt && f7 != 7'd0) ? rbase + 7'd1 : rbase);
            end
            default: dop = 7'd0;
        endcase
    end

    assign dec.op      = dop;
    assign dec.rs1     = in_inst[19:15];
    assign dec.rs2     = in_inst[24:20];
    assign dec.rd      = in_inst[11:7];
    assign dec.imm     = (dop == 7'd0) ? 32'd0 : dimm;
    assign dec.pc      = in_pc;
    assign dec.target  = (jump && dop != 7'd0) ? in_pc + dimm : in_pc + 32'd4;
    assign dec.illegal = (dop == 7'd0);

    assign in_ready  = rdy_in & ~rst_in & (count < DEPTH_N);
    assign out_valid = rdy_in & (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    mem[tail] <= dec;
                    tail      <= tail + DEPTH_WIDTH'(1);
                end
                if (pop) head <= head + DEPTH_WIDTH'(1);
                count <= count + {{DEPTH_WIDTH{1'b0}}, push} - {{DEPTH_WIDTH{1'b0}}, pop};
            end
        end
    end

    // stale storage after flush/pop must never leak out, so fields are gated by occupancy
    assign head_ent    = (count != '0) ? mem[head] : '0;
    assign out_op      = head_ent.op;
    assign out_rs1     = head_ent.rs1;
    assign out_rs2     = head_ent.rs2;
    assign out_rd      = head_ent.rd;
    assign out_imm     = head_ent.imm;
    assign out_pc      = head_ent.pc;
    assign out_target  = head_ent.target;
    assign out_illegal = head_ent.illegal;
endmodule
